// File: rtl/stream_pack_ctrl.sv
// stream_pack_ctrl: pairs 32-bit stream words into 64-bit beats, applying a
// per-pair reorder (pass / byte reverse / halfword swap / bit reverse).
// Optional statistics counters are enabled with `define STREAM_PACK_STATS_EN.
module stream_pack_ctrl #(
  parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_i,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        flush_i,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_half,
  output logic        out_last,
  output logic        busy
`ifdef STREAM_PACK_STATS_EN
  ,
  output logic [15:0] pair_count,
  output logic [7:0]  flush_count
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEAT_W = 64;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [BEAT_W-1:0]   data_d;
  logic                valid_d, half_d, last_d;

  // Streaming reorder of one word
  function automatic logic [WORD_W-1:0] reorder(input logic [WORD_W-1:0] w,
                                                input logic [1:0] m);
    logic [WORD_W-1:0] r;
    case (m)
      2'd0:    r = w;
      2'd1:    r = {<<8{w}};
      2'd2:    r = {<<16{w}};
      default: r = {<<{w}};
    endcase
    return r;
  endfunction

  // Next-state, handshake and beat assembly
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    data_d   = out_data;
    valid_d  = out_valid;
    half_d   = out_half;
    last_d   = out_last;
    in_ready = 1'b1;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          data_d[BEAT_W-1:WORD_W] = reorder(in_data, mode_i);
          mode_d  = mode_i;
          state_d = HALF;
        end
      end
      HALF: begin
        if (in_valid) begin
          data_d[WORD_W-1:0] = reorder(in_data, mode_q);
          valid_d = 1'b1;
          half_d  = 1'b0;
          last_d  = flush_i;
          state_d = FULL;
        end else if (flush_i) begin
          data_d[WORD_W-1:0] = PAD_WORD;
          valid_d = 1'b1;
          half_d  = 1'b1;
          last_d  = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        in_ready = out_ready;
        if (out_ready) begin
          valid_d = 1'b0;
          half_d  = 1'b0;
          last_d  = 1'b0;
          if (in_valid) begin
            // Pop and accept together: the new word opens the next pair
            data_d[BEAT_W-1:WORD_W] = reorder(in_data, mode_i);
            mode_d  = mode_i;
            state_d = HALF;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      mode_q    <= 2'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_half  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_half  <= half_d;
      out_last  <= last_d;
    end
  end

  assign busy = (state_q != EMPTY);

`ifdef STREAM_PACK_STATS_EN
  // Beat statistics: full pairs wrap, flushed halves saturate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_count  <= 16'd0;
      flush_count <= 8'd0;
    end else if (out_valid && out_ready) begin
      if (!out_half) pair_count <= pair_count + 16'd1;
      else if (flush_count != 8'hFF) flush_count <= flush_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_pack_ctrl.sv
// Self-checking bench for stream_pack_ctrl: directed vector table, corner
// sequences, and a randomized run against a queue-based reference model.
module tb_stream_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_i;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        flush_i;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_half;
  logic        out_last;
  logic        busy;
`ifdef STREAM_PACK_STATS_EN
  logic [15:0] pair_count;
  logic [7:0]  flush_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  stream_pack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .flush_i(flush_i),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_half(out_half), .out_last(out_last), .busy(busy)
`ifdef STREAM_PACK_STATS_EN
    , .pair_count(pair_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  m0;
    logic [31:0] w0;
    logic [1:0]  m1;
    logic [31:0] w1;
    logic        flush_only;
    logic        fl;
    logic [63:0] exp_data;
    logic        exp_half;
    logic        exp_last;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        h;
    logic        l;
  } beat_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference reorder written from bit/byte positions
  function automatic logic [31:0] ref_reorder(input logic [31:0] w, input logic [1:0] m);
    logic [31:0] r;
    r = w;
    if (m == 2'd1) for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    else if (m == 2'd2) r = {w[15:0], w[31:16]};
    else if (m == 2'd3) for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
    in_data = '0; mode_i = 2'd0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    in_valid = 1'b1; in_data = v.w0; mode_i = v.m0; flush_i = 1'b0; out_ready = 1'b0;
    tick();
    if (v.flush_only) begin
      in_valid = 1'b0; flush_i = 1'b1; mode_i = v.m1;
    end else begin
      in_valid = 1'b1; in_data = v.w1; mode_i = v.m1; flush_i = v.fl;
    end
    tick();
    in_valid = 1'b0; flush_i = 1'b0;
    chk($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
    chk($sformatf("vec%0d_data", idx), out_data, v.exp_data);
    chk($sformatf("vec%0d_half", idx), 64'(out_half), 64'(v.exp_half));
    chk($sformatf("vec%0d_last", idx), 64'(out_last), 64'(v.exp_last));
    #1 chk($sformatf("vec%0d_ready_full", idx), 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 chk($sformatf("vec%0d_ready_pop", idx), 64'(in_ready), 64'd1);
    tick();
    chk($sformatf("vec%0d_popped", idx), 64'(out_valid), 64'd0);
    chk($sformatf("vec%0d_idle", idx), 64'(busy), 64'd0);
    out_ready = 1'b0;
  endtask

  vec_t  vecs[6];
  beat_t expq[$];
  logic [31:0] pend_hi;
  logic [1:0]  pend_mode;
  int          pend_n;
  int          m_pairs, m_flushes;

  initial begin
    vecs[0] = '{2'd0, 32'h172A7FFF, 2'd0, 32'hFF7F2A17, 1'b0, 1'b0, 64'h172A7FFF_FF7F2A17, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 32'h172A7FFF, 2'd2, 32'hFF7F2A17, 1'b0, 1'b0, 64'hFF7F2A17_172A7FFF, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 32'h172A7FFF, 2'd0, 32'h0,        1'b1, 1'b1, 64'h7FFF172A_00000000, 1'b1, 1'b1};
    vecs[3] = '{2'd3, 32'h00000001, 2'd1, 32'h0,        1'b1, 1'b1, 64'h80000000_00000000, 1'b1, 1'b1};
    vecs[4] = '{2'd3, 32'h00000001, 2'd0, 32'hF0000000, 1'b0, 1'b0, 64'h80000000_0000000F, 1'b0, 1'b0};
    vecs[5] = '{2'd0, 32'h00000001, 2'd3, 32'h00000002, 1'b0, 1'b1, 64'h00000001_00000002, 1'b0, 1'b1};

    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_half", 64'(out_half), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", out_data, 64'd0);
    #1 chk("rst_ready", 64'(in_ready), 64'd1);

`ifdef STREAM_PACK_STATS_EN
    chk("rst_pair_count", 64'(pair_count), 64'd0);
    chk("rst_flush_count", 64'(flush_count), 64'd0);
    out_ready = 1'b1; mode_i = 2'd0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 32'(i); tick();
    end
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 32'h77; tick();
    in_valid = 1'b0; flush_i = 1'b1; tick();
    flush_i = 1'b0; tick();
    chk("stats_pair_count", 64'(pair_count), 64'd3);
    chk("stats_flush_count", 64'(flush_count), 64'd1);
    out_ready = 1'b0;
`endif

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Backpressure: beat holds, input blocked, then pop+accept in one cycle
    mode_i = 2'd0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1111_1111; tick();
    in_data = 32'h2222_2222; tick();
    in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_data%0d", i), out_data, 64'h11111111_22222222);
      chk($sformatf("bp_hold_ready%0d", i), 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1; in_data = 32'hAAAA_5555; mode_i = 2'd1;
    #1 chk("bp_ready_on_pop", 64'(in_ready), 64'd1);
    tick();
    chk("bp_popped", 64'(out_valid), 64'd0);
    chk("bp_half_state", 64'(busy), 64'd1);
    in_data = 32'h0000_0001; mode_i = 2'd0; tick();
    in_valid = 1'b0;
    chk("bp_next_beat", out_data, 64'h5555AAAA_01000000);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset while half-filled discards the held word
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; tick();
    chk("mid_rst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0; in_valid = 1'b0; tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1; tick();
    chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
    in_data = 32'h2; tick();
    in_valid = 1'b0;
    chk("mid_rst_valid_beat", 64'(out_valid), 64'd1);
    chk("mid_rst_beat", out_data, 64'h00000001_00000002);
    chk("mid_rst_half", 64'(out_half), 64'd0);
    tick();
    chk("mid_rst_after", 64'(out_valid), 64'd0);

    // Randomized run against the reference model
    do_reset();
    pend_n = 0; m_pairs = 0; m_flushes = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic exp_ready, acc;
      in_valid  = ($urandom_range(0, 9) < 6);
      in_data   = $urandom;
      mode_i    = 2'($urandom_range(0, 3));
      flush_i   = ($urandom_range(0, 9) < 2);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_ready = (expq.size() == 0) || out_ready;
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_ready));
      chk("rnd_out_valid", 64'(out_valid), 64'(expq.size() != 0));
      if (expq.size() != 0 && out_ready) begin
        beat_t b;
        b = expq.pop_front();
        chk("rnd_data", out_data, b.d);
        chk("rnd_half", 64'(out_half), 64'(b.h));
        chk("rnd_last", 64'(out_last), 64'(b.l));
        if (b.h) begin
          if (m_flushes < 255) m_flushes++;
        end else m_pairs++;
      end
      acc = in_valid && exp_ready;
      if (acc && pend_n == 0) begin
        pend_hi = ref_reorder(in_data, mode_i); pend_mode = mode_i; pend_n = 1;
      end else if (acc) begin
        expq.push_back('{ {pend_hi, ref_reorder(in_data, pend_mode)}, 1'b0, flush_i });
        pend_n = 0;
      end else if (flush_i && pend_n == 1) begin
        expq.push_back('{ {pend_hi, 32'h0000_0000}, 1'b1, 1'b1 });
        pend_n = 0;
      end
      tick();
    end
    in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
`ifdef STREAM_PACK_STATS_EN
    chk("rnd_pair_count", 64'(pair_count), 64'(16'(m_pairs)));
    chk("rnd_flush_count", 64'(flush_count), 64'(8'(m_flushes)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
